// File: rtl/ir_filters_pkg.sv
// Shared types and constants for the frame-to-FIFO path: FSM encoding,
// counter width and the per-beat marker bundle.
package ir_filters_pkg;

  localparam int CNT_W = 12;
  localparam int CFG_W = 16;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } frm_state_e;

  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } frm_markers_t;

endpackage

// File: rtl/frame2fifo_if.sv
// Pixel stream handshake with frame/line markers. The upstream source
// uses the master modport; the frame2fifo sink uses the slave modport.
interface frame2fifo_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  val;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eof;
  logic                  sol;
  logic                  eol;

  modport master (output val, data, sof, eof, sol, eol, input rdy);
  modport slave  (input val, data, sof, eof, sol, eol, output rdy);
endinterface

// File: rtl/frm_marker_chk.sv
// Compares the markers of one beat against those expected at position
// (pix, line) of a w x h frame.
module frm_marker_chk
  import ir_filters_pkg::*;
(
  input  logic [CNT_W-1:0] pix,
  input  logic [CNT_W-1:0] line,
  input  logic [CFG_W-1:0] w,
  input  logic [CFG_W-1:0] h,
  input  logic             sof,
  input  logic             eof,
  input  logic             sol,
  input  logic             eol,
  output logic             match,
  output logic             sof_seen
);

  logic first_pix, last_pix, first_line, last_line;
  frm_markers_t exp_mk, got_mk;

  assign first_pix  = (pix == '0);
  assign first_line = (line == '0);
  assign last_pix   = (CFG_W'(pix) == w - CFG_W'(1));
  assign last_line  = (CFG_W'(line) == h - CFG_W'(1));

  assign exp_mk = '{sof: first_pix & first_line,
                    eof: last_pix & last_line,
                    sol: first_pix,
                    eol: last_pix};
  assign got_mk = '{sof: sof, eof: eof, sol: sol, eol: eol};

  assign match    = (exp_mk == got_mk);
  assign sof_seen = sof;

endmodule

// File: rtl/frame2fifo.sv
// Forwards marker-checked pixel frames into a FIFO with 1-cycle latency.
// Optional FRAME2FIFO_FRM_CNT_EN adds a 16-bit completed-frame counter.
module frame2fifo
  import ir_filters_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst,
  input  logic [15:0]           cfg_img_w,
  input  logic [15:0]           cfg_img_h,
  frame2fifo_if.slave           m_frm,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_pushdata,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  frm_done,
  output logic                  err_sync
`ifdef FRAME2FIFO_FRM_CNT_EN
  ,
  output logic [15:0]           frm_cnt
`endif
);

  frm_state_e       state;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic [CFG_W-1:0] img_w, img_h;
  logic             xfer, match, sof_seen;

  // Discarding never needs FIFO space, so WAIT_SOF always accepts.
  assign m_frm.rdy = (state == WAIT_SOF) | (~fifo_almost_full & ~fifo_full);
  assign xfer      = m_frm.val & m_frm.rdy;

  frm_marker_chk u_chk (
    .pix      (pix_cnt),
    .line     (line_cnt),
    .w        (img_w),
    .h        (img_h),
    .sof      (m_frm.sof),
    .eof      (m_frm.eof),
    .sol      (m_frm.sol),
    .eol      (m_frm.eol),
    .match    (match),
    .sof_seen (sof_seen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the data path, is reset so that
    // fifo_pushdata reads 0 after reset rather than X.
    if (!rst_n) begin
      state         <= WAIT_SOF;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      img_w         <= '0;
      img_h         <= '0;
      fifo_push     <= 1'b0;
      fifo_pushdata <= '0;
      frm_done      <= 1'b0;
      err_sync      <= 1'b0;
    end else if (sw_rst) begin
      state         <= WAIT_SOF;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      img_w         <= '0;
      img_h         <= '0;
      fifo_push     <= 1'b0;
      fifo_pushdata <= '0;
      frm_done      <= 1'b0;
      err_sync      <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are raised below, so each
      // stays high for exactly one cycle without extra clearing logic.
      fifo_push <= 1'b0;
      frm_done  <= 1'b0;
      if (fifo_push && fifo_full) err_sync <= 1'b1;

      if (xfer) begin
        case (state)
          WAIT_SOF: begin
            if (m_frm.sof) begin
              state         <= RUN;
              pix_cnt       <= CNT_W'(1);
              line_cnt      <= '0;
              img_w         <= cfg_img_w;
              img_h         <= cfg_img_h;
              fifo_push     <= 1'b1;
              fifo_pushdata <= m_frm.data;
            end
          end
          RUN: begin
            if (match) begin
              // Markers equal the expected ones, so eol/eof mark the wrap points.
              fifo_push     <= 1'b1;
              fifo_pushdata <= m_frm.data;
              if (m_frm.eof) begin
                state    <= WAIT_SOF;
                pix_cnt  <= '0;
                line_cnt <= '0;
                frm_done <= 1'b1;
              end else if (m_frm.eol) begin
                pix_cnt  <= '0;
                line_cnt <= line_cnt + CNT_W'(1);
              end else begin
                pix_cnt  <= pix_cnt + CNT_W'(1);
              end
            end else if (sof_seen) begin
              err_sync      <= 1'b1;
              pix_cnt       <= CNT_W'(1);
              line_cnt      <= '0;
              img_w         <= cfg_img_w;
              img_h         <= cfg_img_h;
              fifo_push     <= 1'b1;
              fifo_pushdata <= m_frm.data;
            end else begin
              err_sync <= 1'b1;
              state    <= WAIT_SOF;
              pix_cnt  <= '0;
              line_cnt <= '0;
            end
          end
          default: state <= WAIT_SOF;
        endcase
      end
    end
  end

`ifdef FRAME2FIFO_FRM_CNT_EN
  // Counts on the same edge that raises frm_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
    end else if (sw_rst) begin
      frm_cnt <= '0;
    end else if (xfer && state == RUN && match && m_frm.eof) begin
      frm_cnt <= frm_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame2fifo.sv
// Directed bench for frame2fifo: normal frames, dropping, backpressure,
// marker errors, FIFO overflow, config hold and soft reset.
module tb_frame2fifo;
  import ir_filters_pkg::*;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst = 1'b0;
  logic [15:0]   cfg_img_w = 16'd4;
  logic [15:0]   cfg_img_h = 16'd2;
  logic          fifo_push;
  logic [DW-1:0] fifo_pushdata;
  logic          fifo_full = 1'b0;
  logic          fifo_almost_full = 1'b0;
  logic          frm_done;
  logic          err_sync;
`ifdef FRAME2FIFO_FRM_CNT_EN
  logic [15:0]   frm_cnt;
`endif

  frame2fifo_if #(.DATA_WIDTH(DW)) frm_if ();

  frame2fifo #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sw_rst           (sw_rst),
    .cfg_img_w        (cfg_img_w),
    .cfg_img_h        (cfg_img_h),
    .m_frm            (frm_if),
    .fifo_push        (fifo_push),
    .fifo_pushdata    (fifo_pushdata),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .frm_done         (frm_done),
    .err_sync         (err_sync)
`ifdef FRAME2FIFO_FRM_CNT_EN
    ,
    .frm_cnt          (frm_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int push_total = 0;

  always @(negedge clk) if (fifo_push === 1'b1) push_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Correct markers {sof, eof, sol, eol} for position (p, l) of a w x h frame.
  function automatic logic [3:0] mk(input int p, input int l, input int w, input int h);
    return {(p == 0 && l == 0), (p == w - 1 && l == h - 1), (p == 0), (p == w - 1)};
  endfunction

  task automatic idle();
    frm_if.val = 1'b0;
    {frm_if.sof, frm_if.eof, frm_if.sol, frm_if.eol} = 4'b0000;
  endtask

  task automatic idle_cycle();
    idle();
    @(posedge clk); #1;
  endtask

  // Presents one beat, waits (bounded) for rdy, then checks the result
  // visible one cycle after the transfer edge.
  task automatic drive_pix(input string tag, input logic [DW-1:0] d, input logic [3:0] m,
                           input logic exp_push, input logic exp_done);
    int waited = 0;
    frm_if.val  = 1'b1;
    frm_if.data = d;
    {frm_if.sof, frm_if.eof, frm_if.sol, frm_if.eol} = m;
    #1;
    while (!frm_if.rdy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!frm_if.rdy) begin
      check({tag, "_rdy_timeout"}, 32'(frm_if.rdy), 32'd1);
      idle();
      return;
    end
    @(posedge clk); #1;
    check({tag, "_push"}, 32'(fifo_push), 32'(exp_push));
    if (exp_push) check({tag, "_data"}, 32'(fifo_pushdata), 32'(d));
    check({tag, "_done"}, 32'(frm_done), 32'(exp_done));
  endtask

  task automatic send_frame(input string tag, input int w, input int h, input int base,
                            input int first);
    for (int idx = first; idx < w * h; idx++) begin
      drive_pix(tag, DW'(base + idx), mk(idx % w, idx / w, w, h), 1'b1, idx == w * h - 1);
    end
    idle();
  endtask

  task automatic pulse_sw_rst();
    idle();
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    idle();
    frm_if.data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(frm_if.rdy), 32'd1);
    check("rst_push", 32'(fifo_push), 32'd0);
    check("rst_data", 32'(fifo_pushdata), 32'd0);
    check("rst_done", 32'(frm_done), 32'd0);
    check("rst_err", 32'(err_sync), 32'd0);
    check("rst_state", 32'(dut.state), 32'(WAIT_SOF));
    check("rst_pix", 32'(dut.pix_cnt), 32'd0);
`ifdef FRAME2FIFO_FRM_CNT_EN
    check("rst_frm_cnt", 32'(frm_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x2 frame, continuous valid
    p0 = push_total;
    send_frame("basic", 4, 2, 'h100, 0);
    idle_cycle();
    check("basic_pushes", 32'(push_total - p0), 32'd8);
    check("basic_push_low", 32'(fifo_push), 32'd0);
    check("basic_err", 32'(err_sync), 32'd0);

    // three beats without sof are discarded, then a clean frame
    p0 = push_total;
    drive_pix("nosof0", 'h200, 4'b0010, 1'b0, 1'b0);
    drive_pix("nosof1", 'h201, 4'b0000, 1'b0, 1'b0);
    drive_pix("nosof2", 'h202, 4'b0001, 1'b0, 1'b0);
    send_frame("after_drop", 4, 2, 'h300, 0);
    idle_cycle();
    check("after_drop_pushes", 32'(push_total - p0), 32'd8);
    check("after_drop_err", 32'(err_sync), 32'd0);

    // smallest legal frame: 2x1
    cfg_img_w = 16'd2;
    cfg_img_h = 16'd1;
    send_frame("tiny", 2, 1, 'h380, 0);
    cfg_img_w = 16'd4;
    cfg_img_h = 16'd2;
    idle_cycle();

    // almost_full held for 5 cycles while pixel 3 is offered
    p0 = push_total;
    for (int i = 0; i < 3; i++) drive_pix("af_pre", DW'('h400 + i), mk(i, 0, 4, 2), 1'b1, 1'b0);
    frm_if.val = 1'b1;
    frm_if.data = DW'('h403);
    {frm_if.sof, frm_if.eof, frm_if.sol, frm_if.eol} = mk(3, 0, 4, 2);
    fifo_almost_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("af_rdy_low", 32'(frm_if.rdy), 32'd0);
      @(posedge clk); #1;
      check("af_no_push", 32'(fifo_push), 32'd0);
    end
    fifo_almost_full = 1'b0;
    send_frame("af_post", 4, 2, 'h400, 3);
    idle_cycle();
    check("af_pushes", 32'(push_total - p0), 32'd8);

    // eol missing at pixel 3 of line 0
    for (int i = 0; i < 3; i++) drive_pix("eol_pre", DW'('h500 + i), mk(i, 0, 4, 2), 1'b1, 1'b0);
    drive_pix("eol_miss", 'h503, 4'b0000, 1'b0, 1'b0);
    check("eol_miss_err", 32'(err_sync), 32'd1);
    check("eol_miss_state", 32'(dut.state), 32'(WAIT_SOF));
    p0 = push_total;
    send_frame("recover", 4, 2, 'h600, 0);
    idle_cycle();
    check("recover_pushes", 32'(push_total - p0), 32'd8);
    check("err_sticky", 32'(err_sync), 32'd1);
`ifdef FRAME2FIFO_FRM_CNT_EN
    check("frm_cnt_5", 32'(frm_cnt), 32'd5);
`endif
    pulse_sw_rst();
    check("sw_rst_err_clr", 32'(err_sync), 32'd0);
`ifdef FRAME2FIFO_FRM_CNT_EN
    check("sw_rst_frm_cnt", 32'(frm_cnt), 32'd0);
`endif

    // sof arriving at (2,1) restarts the frame
    for (int i = 0; i < 6; i++) drive_pix("sof_pre", DW'('h700 + i), mk(i % 4, i / 4, 4, 2), 1'b1, 1'b0);
    drive_pix("sof_mid", 'h7AA, 4'b1010, 1'b1, 1'b0);
    check("sof_mid_err", 32'(err_sync), 32'd1);
    check("sof_mid_state", 32'(dut.state), 32'(RUN));
    send_frame("restart", 4, 2, 'h800, 1);
    idle_cycle();
    pulse_sw_rst();

    // push into a full FIFO, and cfg change mid-frame is ignored
    fifo_full = 1'b1;
    drive_pix("full_sof", 'h900, mk(0, 0, 4, 2), 1'b1, 1'b0);
    idle();
    cfg_img_w = 16'd6;
    cfg_img_h = 16'd3;
    @(posedge clk); #1;
    check("full_err", 32'(err_sync), 32'd1);
    fifo_full = 1'b0;
    send_frame("full_rest", 4, 2, 'h900, 1);
    cfg_img_w = 16'd4;
    cfg_img_h = 16'd2;
    idle_cycle();
`ifdef FRAME2FIFO_FRM_CNT_EN
    check("frm_cnt_1", 32'(frm_cnt), 32'd1);
`endif

    // sw_rst coincides with pixel 5 while pixel 4's push is on the bus
    for (int i = 0; i < 5; i++) drive_pix("swr_pre", DW'('hA00 + i), mk(i % 4, i / 4, 4, 2), 1'b1, 1'b0);
    frm_if.val = 1'b1;
    frm_if.data = DW'('hA05);
    {frm_if.sof, frm_if.eof, frm_if.sol, frm_if.eol} = mk(1, 1, 4, 2);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    check("swr_push", 32'(fifo_push), 32'd0);
    check("swr_pix", 32'(dut.pix_cnt), 32'd0);
    check("swr_line", 32'(dut.line_cnt), 32'd0);
    check("swr_state", 32'(dut.state), 32'(WAIT_SOF));
    check("swr_err", 32'(err_sync), 32'd0);
    check("swr_done", 32'(frm_done), 32'd0);
`ifdef FRAME2FIFO_FRM_CNT_EN
    check("swr_frm_cnt", 32'(frm_cnt), 32'd0);
`endif
    sw_rst = 1'b0;
    idle_cycle();
    check("swr_rdy", 32'(frm_if.rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
